// File: rtl/arb_pkg.sv
// arb_pkg: shared enums and index helper for the round-robin/priority arbiter.
package arb_pkg;
    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
    function automatic int bit_to_idx(int b, int n);
        return n - 1 - b;
    endfunction
endpackage

// File: rtl/rr_priority_arbiter_if.sv
// rr_priority_arbiter_if: request/grant bundle between sources, arbiter and consumer.
interface rr_priority_arbiter_if #(parameter int N = 8);
    localparam int W = $clog2(N);
    logic [N-1:0] req;
    logic         mode;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    modport master (output req, mode, gnt_ready, input gnt_valid, gnt_idx);
    modport slave (input req, mode, gnt_ready, output gnt_valid, gnt_idx);
endinterface

// File: rtl/pe_find_first.sv
// pe_find_first: lowest encoded index e (= N-1-b) among set bits of v.
module pe_find_first import arb_pkg::*; #(parameter int N = 8) (
    input  logic [N-1:0]         v,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);
    always_comb begin
        found = |v;
        idx = '0;
        // ascending bit order: the last hit is the highest bit, i.e. the lowest e
        for (int b = 0; b < N; b++)
            if (v[b]) idx = W'(bit_to_idx(b, N));
    end
endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: registered N-way fixed/round-robin arbiter with a valid/ready grant.
module rr_priority_arbiter import arb_pkg::*; #(parameter int N = 8) (
    input logic                  clk,
    input logic                  rst,
    rr_priority_arbiter_if.slave bus
);
    localparam int W = $clog2(N);
    arb_state_e   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, m_idx, r_idx;
    logic [N-1:0] mask;
    logic         m_found, r_found, rr, load;

    pe_find_first #(.N(N)) u_masked (.v(bus.req & mask), .found(m_found), .idx(m_idx));
    pe_find_first #(.N(N)) u_raw (.v(bus.req), .found(r_found), .idx(r_idx));

    // the search on an accept cycle already starts past the grant being retired
    always_comb begin
        rr = bus.mode == ARB_RR;
        ptr_d = (state_q == GRANT && bus.gnt_ready && rr) ?
                (gnt_idx_q == W'(N - 1) ? '0 : gnt_idx_q + 1'b1) : ptr_q;
        mask = '0;
        for (int b = 0; b < N; b++)
            mask[b] = bit_to_idx(b, N) >= int'(ptr_d);
    end

    always_comb begin
        load = state_q == IDLE || bus.gnt_ready;
        state_d = load ? (r_found ? GRANT : IDLE) : state_q;
        gnt_idx_d = (load && r_found) ? ((rr && m_found) ? m_idx : r_idx) : gnt_idx_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end

    assign bus.gnt_valid = state_q == GRANT;
    assign bus.gnt_idx = gnt_idx_q;
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: directed plan plus randomized traffic against a rotation-search model.
module tb_rr_priority_arbiter;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errors = 0;
    int mi = 0, mp = 0;
    logic mv = 1'b0;

    rr_priority_arbiter_if #(.N(N)) bus ();
    rr_priority_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // search e-space starting at s, wrapping, for the first requesting line
    function automatic int pick(logic [N-1:0] r, logic m, int p);
        int s = m ? p : 0;
        for (int k = 0; k < N; k++) begin
            int e = (s + k) % N;
            if (r[N-1-e]) return e;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        int np;
        if (rst) begin
            mv <= 1'b0;
            mi <= 0;
            mp <= 0;
        end else if (!mv || bus.gnt_ready) begin
            np = (mv && bus.gnt_ready && bus.mode) ? (mi + 1) % N : mp;
            mp <= np;
            mv <= bus.req != '0;
            if (bus.req != '0) mi <= pick(bus.req, bus.mode, np);
        end
    end

    always @(negedge clk)
        if (!rst) begin
            chk("model_valid", {31'b0, bus.gnt_valid}, {31'b0, mv});
            chk("model_idx", {29'b0, bus.gnt_idx}, mi);
        end

    task automatic tick(logic [N-1:0] r, logic m, logic rd);
        bus.req = r;
        bus.mode = m;
        bus.gnt_ready = rd;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(string nm, logic v, int idx);
        chk({nm, "_valid"}, {31'b0, bus.gnt_valid}, {31'b0, v});
        if (v) chk({nm, "_idx"}, {29'b0, bus.gnt_idx}, idx);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.mode = 1'b0;
        bus.gnt_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        lit("reset", 1'b0, 0);
        chk("reset_idx", {29'b0, bus.gnt_idx}, 0);
        for (int i = 0; i < 5; i++) begin
            tick('0, 1'b0, 1'b1);
            lit("idle", 1'b0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(8'b0100_0001, 1'b0, 1'b1);
            lit("fixed", 1'b1, 1);
        end
        tick('0, 1'b0, 1'b1);
        lit("drain", 1'b0, 0);
        tick(8'b0000_1000, 1'b0, 1'b0);
        lit("hold_load", 1'b1, 4);
        for (int i = 0; i < 2; i++) begin
            tick(8'b1000_0000, 1'b0, 1'b0);
            lit("hold", 1'b1, 4);
        end
        tick(8'b1000_0000, 1'b0, 1'b1);
        lit("after_hold", 1'b1, 0);
        pulse_rst();
        for (int i = 0; i < 9; i++) begin
            tick(8'hFF, 1'b1, 1'b1);
            lit("rotate", 1'b1, i % N);
        end
        tick(8'b0010_0000, 1'b1, 1'b1);
        lit("rr_e2", 1'b1, 2);
        tick(8'b1000_0001, 1'b1, 1'b1);
        lit("rr_wrap7", 1'b1, 7);
        tick(8'b1000_0001, 1'b1, 1'b1);
        lit("rr_wrap0", 1'b1, 0);
        tick(8'b0000_0100, 1'b1, 1'b1);
        lit("pend5", 1'b1, 5);
        tick(8'b0000_0100, 1'b1, 1'b0);
        lit("pend5_hold", 1'b1, 5);
        rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, bus.gnt_valid}, 0);
        chk("async_idx", {29'b0, bus.gnt_idx}, 0);
        #1;
        rst = 1'b0;
        tick(8'hFF, 1'b1, 1'b1);
        lit("post_rst", 1'b1, 0);
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 3);
            logic [N-1:0] r = sel == 0 ? '0 : sel == 1 ? N'(1) << $urandom_range(0, N - 1) :
                              sel == 2 ? N'($urandom) : '1;
            if ($urandom_range(0, 199) == 0) pulse_rst();
            tick(r, ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, $urandom_range(0, 9) < 7);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
